fp_mul_iter: RTL and testbench

//  Iterative (shift-add) IEEE-754-style floating-point multiplier, generalised in exponent/fraction width.

---
 rtl/fp_mul_pkg.sv | 20 ++
 rtl/fp_mul_classify.sv | 32 +++
 rtl/fp_mul_iter.sv | 212 +++++++++++++++++++++
 tb/tb_fp_mul_iter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types for the iterative floating-point multiplier.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package fp_mul_pkg;

  typedef enum logic [2:0] {IDLE, CLASS, MUL, NORM, ROUND, DONE} state_t;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

  // Bit positions inside the 4-bit flags output {invalid, overflow, underflow, inexact}.
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  function automatic int bias(input int exp_bits);
    return (1 << (exp_bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_mul_classify.sv
// Classifies one packed {sign, exponent, fraction} operand as zero / normal / inf / NaN.
// Latency: combinational.
// Backpressure: none.
// Ports: op_i - packed operand; cls_o - class. Exponent 0 counts as zero (denormals flushed).
module fp_classify
  import fp_mul_pkg::*;
#(
  parameter int EXP_BITS  = 8,
  parameter int FRAC_BITS = 23
) (
  input  logic [EXP_BITS+FRAC_BITS:0] op_i,
  output fp_class_t                   cls_o
);

  logic [EXP_BITS-1:0]  exp_w;
  logic [FRAC_BITS-1:0] frac_w;
  logic                 unused_sign;

  assign exp_w       = op_i[FRAC_BITS +: EXP_BITS];
  assign frac_w      = op_i[FRAC_BITS-1:0];
  assign unused_sign = op_i[EXP_BITS+FRAC_BITS];

  always_comb begin
    cls_o = FP_NORM;
    if (exp_w == '0) begin
      cls_o = FP_ZERO;
    end else if (exp_w == '1) begin
      cls_o = (frac_w == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fp_mul_iter.sv
// Iterative shift-add floating-point multiplier, round-to-nearest-even, denormals flushed to zero.
// Latency: MANT_W+3 cycles accept-to-out_valid for finite nonzero operands, 2 cycles for specials.
// Backpressure: single op in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk/reset (sync, active-high); in_valid/in_ready/a/b operand handshake;
//        out_valid/out_ready/result/flags result handshake, flags = {invalid, overflow, underflow, inexact}.
module fp_mul_iter
  import fp_mul_pkg::*;
#(
  parameter int EXP_BITS  = 8,
  parameter int FRAC_BITS = 23
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [EXP_BITS+FRAC_BITS:0]   a,
  input  logic [EXP_BITS+FRAC_BITS:0]   b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [EXP_BITS+FRAC_BITS:0]   result,
  output logic [3:0]                    flags
);

  localparam int W      = 1 + EXP_BITS + FRAC_BITS;
  localparam int MANT_W = FRAC_BITS + 1;
  localparam int PW     = 2 * MANT_W;
  localparam int XW     = EXP_BITS + 2;
  localparam int CW     = $clog2(MANT_W);

  localparam logic [XW-1:0] BIAS_X   = XW'(bias(EXP_BITS));
  localparam logic [XW-1:0] EMAX_X   = {2'b00, {EXP_BITS{1'b1}}};
  localparam logic [CW-1:0] CNT_LAST = CW'(MANT_W - 1);

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

  state_t               state_q, state_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic [MANT_W-1:0]    mcand_q, mcand_d;
  logic [XW-1:0]        exp_q, exp_d;
  logic                 sign_q, sign_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 spec_q, spec_d;
  logic [W-1:0]         result_q, result_d;
  logic [3:0]           flags_q, flags_d;

  fp_class_t            cls_a, cls_b;

  fp_classify #(.EXP_BITS(EXP_BITS), .FRAC_BITS(FRAC_BITS)) u_cls_a (.op_i(a_q), .cls_o(cls_a));
  fp_classify #(.EXP_BITS(EXP_BITS), .FRAC_BITS(FRAC_BITS)) u_cls_b (.op_i(b_q), .cls_o(cls_b));

  // Special-case result, computed from the captured operands.
  logic          special;
  logic [W-1:0]  spec_res;
  logic          spec_inv;
  logic          sign_ab;

  assign sign_ab = a_q[W-1] ^ b_q[W-1];
  assign special = (cls_a != FP_NORM) || (cls_b != FP_NORM);

  always_comb begin
    spec_res = {sign_ab, {(W-1){1'b0}}};
    spec_inv = 1'b0;
    if (cls_a == FP_NAN || cls_b == FP_NAN ||
        (cls_a == FP_INF && cls_b == FP_ZERO) || (cls_a == FP_ZERO && cls_b == FP_INF)) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (cls_a == FP_INF || cls_b == FP_INF) begin
      spec_res = {sign_ab, {EXP_BITS{1'b1}}, {FRAC_BITS{1'b0}}};
    end
  end

  // One shift-add step: the low half of prod_q starts as the multiplier and is consumed LSB first,
  // the high half accumulates; the whole register shifts right each step.
  logic [MANT_W:0] acc;
  assign acc = {1'b0, prod_q[PW-1:MANT_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

  // Rounding on the normalised product: leading one sits at bit 2*FRAC_BITS.
  logic [MANT_W-1:0]    mant;
  logic                 guard, sticky, round_up;
  logic [MANT_W:0]      mant_r;
  logic [XW-1:0]        exp_r;
  logic [FRAC_BITS-1:0] frac_r;
  logic                 unused_hidden;

  assign mant          = prod_q[2*FRAC_BITS -: MANT_W];
  assign guard         = prod_q[FRAC_BITS-1];
  assign sticky        = |prod_q[FRAC_BITS-2:0];
  assign round_up      = guard & (sticky | mant[0]);
  assign mant_r        = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
  // Carry out of the mantissa means 10.000..0: fraction becomes zero, exponent bumps.
  assign exp_r         = exp_q + {{(XW-1){1'b0}}, mant_r[MANT_W]};
  assign frac_r        = mant_r[MANT_W] ? '0 : mant_r[FRAC_BITS-1:0];
  assign unused_hidden = mant_r[FRAC_BITS];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    spec_d   = spec_q;
    result_d = result_q;
    flags_d  = flags_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          flags_d = '0;
          spec_d  = 1'b0;
          state_d = CLASS;
        end
      end
      CLASS: begin
        sign_d = sign_ab;
        if (special) begin
          // Specials spend a second CLASS cycle before the result is registered.
          if (!spec_q) begin
            spec_d = 1'b1;
          end else begin
            spec_d            = 1'b0;
            result_d          = spec_res;
            flags_d           = '0;
            flags_d[FLG_INV]  = spec_inv;
            state_d           = DONE;
          end
        end else begin
          mcand_d = {1'b1, a_q[FRAC_BITS-1:0]};
          prod_d  = {{MANT_W{1'b0}}, 1'b1, b_q[FRAC_BITS-1:0]};
          exp_d   = {2'b00, a_q[FRAC_BITS +: EXP_BITS]} + {2'b00, b_q[FRAC_BITS +: EXP_BITS]} - BIAS_X;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        prod_d = {acc, prod_q[MANT_W-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (prod_q[PW-1]) begin
          // Keep the bit shifted out folded into bit 0 so it still contributes to sticky.
          prod_d = {1'b0, prod_q[PW-1:2], prod_q[1] | prod_q[0]};
          exp_d  = exp_q + 1'b1;
        end
        state_d = ROUND;
      end
      ROUND: begin
        result_d         = {sign_q, exp_r[EXP_BITS-1:0], frac_r};
        flags_d          = '0;
        flags_d[FLG_INX] = guard | sticky;
        if (!exp_r[XW-1] && exp_r >= EMAX_X) begin
          result_d         = {sign_q, {EXP_BITS{1'b1}}, {FRAC_BITS{1'b0}}};
          flags_d[FLG_OVF] = 1'b1;
          flags_d[FLG_INX] = 1'b1;
        end else if (exp_r[XW-1] || exp_r == '0) begin
          result_d         = {sign_q, {(W-1){1'b0}}};
          flags_d[FLG_UNF] = 1'b1;
          flags_d[FLG_INX] = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      spec_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      spec_q   <= spec_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_iter.sv
// Self-checking bench: single (8/23) and half (5/10) instances against an integer-arithmetic model.
// Latency: n/a.
// Backpressure: exercises held results with out_ready low.
module tb_fp_mul_iter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        sp_in_valid, sp_in_ready, sp_out_valid, sp_out_ready;
  logic [31:0] sp_a, sp_b, sp_result;
  logic [3:0]  sp_flags;

  logic        hp_in_valid, hp_in_ready, hp_out_valid, hp_out_ready;
  logic [15:0] hp_a, hp_b, hp_result;
  logic [3:0]  hp_flags;

  fp_mul_iter #(.EXP_BITS(8), .FRAC_BITS(23)) u_sp (
    .clk(clk), .reset(reset), .in_valid(sp_in_valid), .in_ready(sp_in_ready),
    .a(sp_a), .b(sp_b), .out_valid(sp_out_valid), .out_ready(sp_out_ready),
    .result(sp_result), .flags(sp_flags));

  fp_mul_iter #(.EXP_BITS(5), .FRAC_BITS(10)) u_hp (
    .clk(clk), .reset(reset), .in_valid(hp_in_valid), .in_ready(hp_in_ready),
    .a(hp_a), .b(hp_b), .out_valid(hp_out_valid), .out_ready(hp_out_ready),
    .result(hp_result), .flags(hp_flags));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, normalise, round half-to-even on the remainder.
  function automatic void model(input int E, input int F, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] res, output logic [3:0] flg, output int lat);
    longint emax  = (longint'(1) << E) - 1;
    longint bias  = (longint'(1) << (E - 1)) - 1;
    longint fmask = (longint'(1) << F) - 1;
    longint ea = (longint'(av) >> F) & emax;
    longint eb = (longint'(bv) >> F) & emax;
    longint fa = longint'(av) & fmask;
    longint fb = longint'(bv) & fmask;
    longint sgn = longint'(av[E+F] ^ bv[E+F]) << (E + F);
    bit a_nan = (ea == emax) && (fa != 0);
    bit b_nan = (eb == emax) && (fb != 0);
    bit a_inf = (ea == emax) && (fa == 0);
    bit b_inf = (eb == emax) && (fb == 0);
    bit a_zero = (ea == 0);
    bit b_zero = (eb == 0);
    longint p, q, rem, half, e, r;
    int sh;
    flg = 4'b0000;
    lat = 2;
    r   = sgn;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      r   = (emax << F) | (longint'(1) << (F - 1));
      flg = 4'b1000;
    end else if (a_inf || b_inf) begin
      r = sgn | (emax << F);
    end else if (a_zero || b_zero) begin
      r = sgn;
    end else begin
      lat = F + 4;
      p  = (fa | (longint'(1) << F)) * (fb | (longint'(1) << F));
      e  = ea + eb - bias;
      sh = F;
      if (p >= (longint'(1) << (2 * F + 1))) begin
        sh = F + 1;
        e  = e + 1;
      end
      q    = p >> sh;
      rem  = p & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (q & 1) != 0)) q = q + 1;
      if (q == (longint'(1) << (F + 1))) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= emax) begin
        r   = sgn | (emax << F);
        flg = 4'b0101;
      end else if (e <= 0) begin
        r   = sgn;
        flg = 4'b0011;
      end else begin
        r   = sgn | (e << F) | (q & fmask);
        flg = {3'b000, rem != 0};
      end
    end
    res = r[31:0];
  endfunction

  function automatic logic [31:0] rand_op(input int E, input int F);
    logic [31:0] s, e, f;
    int emax = (1 << E) - 1;
    int r    = $urandom_range(0, 15);
    s = $urandom_range(0, 1);
    e = $urandom_range(0, emax);
    f = $urandom & ((32'd1 << F) - 1);
    if (r == 0) e = 0;
    if (r == 1) begin
      e = emax;
      if ($urandom_range(0, 1) == 0) f = 0;
    end
    if (r == 2) f = 0;
    if (r == 3) f = (32'd1 << F) - 1;
    return (s << (E + F)) | (e << F) | f;
  endfunction

  task automatic start_op(input int inst, input logic [31:0] av, input logic [31:0] bv);
    chk("in_ready_idle", (inst == 0) ? sp_in_ready : hp_in_ready, 1);
    if (inst == 0) begin
      sp_a = av; sp_b = bv; sp_in_valid = 1'b1;
    end else begin
      hp_a = av[15:0]; hp_b = bv[15:0]; hp_in_valid = 1'b1;
    end
    @(posedge clk); #1;
    sp_in_valid = 1'b0;
    hp_in_valid = 1'b0;
  endtask

  task automatic wait_done(input int inst, output int lat);
    lat = 0;
    for (int i = 1; i <= 100 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (((inst == 0) ? sp_out_valid : hp_out_valid) === 1'b1) lat = i;
    end
    if (lat == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic take_result(input int inst, output logic [31:0] res, output logic [3:0] flg);
    if (inst == 0) begin
      res = sp_result; flg = sp_flags; sp_out_ready = 1'b1;
    end else begin
      res = {16'h0, hp_result}; flg = hp_flags; hp_out_ready = 1'b1;
    end
    @(posedge clk); #1;
    sp_out_ready = 1'b0;
    hp_out_ready = 1'b0;
  endtask

  task automatic run_check(input int inst, input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] xres, input logic [3:0] xflg, input int xlat);
    int          lat;
    logic [31:0] res;
    logic [3:0]  flg;
    start_op(inst, av, bv);
    wait_done(inst, lat);
    take_result(inst, res, flg);
    chk({tag, "_result"}, res, xres);
    chk({tag, "_flags"}, flg, xflg);
    chk({tag, "_latency"}, lat, xlat);
  endtask

  task automatic run_random(input int inst, input int E, input int F, input int n);
    logic [31:0] av, bv, xres;
    logic [3:0]  xflg;
    int          xlat;
    for (int k = 0; k < n; k++) begin
      av = rand_op(E, F);
      bv = rand_op(E, F);
      model(E, F, av, bv, xres, xflg, xlat);
      run_check(inst, (inst == 0) ? "rnd_sp" : "rnd_hp", av, bv, xres, xflg, xlat);
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    logic [3:0]  flg;

    reset = 1'b1;
    sp_in_valid = 1'b0; sp_out_ready = 1'b0; sp_a = '0; sp_b = '0;
    hp_in_valid = 1'b0; hp_out_ready = 1'b0; hp_a = '0; hp_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_in_ready", sp_in_ready, 1);
    chk("rst_out_valid", sp_out_valid, 0);
    chk("rst_result", sp_result, 0);
    chk("rst_flags", sp_flags, 0);
    chk("rst_hp_in_ready", hp_in_ready, 1);
    chk("rst_hp_out_valid", hp_out_valid, 0);

    // Single precision directed cases.
    run_check(0, "mul_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
    run_check(0, "mul_m2x3",    32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 27);
    run_check(0, "mul_rne",     32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 27);
    run_check(0, "inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 2);
    run_check(0, "nan_x_one",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2);
    run_check(0, "ninf_x_two",  32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 2);
    run_check(0, "zero_x_neg",  32'h00000000, 32'hC0000000, 32'h80000000, 4'b0000, 2);
    run_check(0, "overflow",    32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 27);
    run_check(0, "underflow",   32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 27);

    // Half precision directed cases.
    run_check(1, "hp_1p5x2",    32'h3E00, 32'h4000, 32'h4200, 4'b0000, 14);
    run_check(1, "hp_m2x3",     32'hC000, 32'h4200, 32'hC600, 4'b0000, 14);
    run_check(1, "hp_inf_zero", 32'h7C00, 32'h0000, 32'h7E00, 4'b1000, 2);
    run_check(1, "hp_overflow", 32'h7BFF, 32'h4000, 32'h7C00, 4'b0101, 14);
    run_check(1, "hp_underflow",32'h0400, 32'h3800, 32'h0000, 4'b0011, 14);

    // Result held under backpressure; operand pulses in DONE must be ignored.
    start_op(0, 32'h3FC00000, 32'h40000000);
    wait_done(0, lat);
    chk("hold_latency", lat, 27);
    for (int i = 0; i < 10; i++) begin
      sp_a = $urandom; sp_b = $urandom; sp_in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      chk("hold_result", sp_result, 32'h40400000);
      chk("hold_flags", sp_flags, 0);
      chk("hold_in_ready", sp_in_ready, 0);
      chk("hold_out_valid", sp_out_valid, 1);
    end
    sp_in_valid = 1'b0;
    take_result(0, res, flg);
    chk("hold_final", res, 32'h40400000);
    chk("after_ack_in_ready", sp_in_ready, 1);
    repeat (30) @(posedge clk);
    #1 chk("no_ghost_op", sp_out_valid, 0);

    // Reset in the middle of MUL aborts the operation.
    start_op(0, 32'h40400000, 32'h40400000);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_in_ready", sp_in_ready, 1);
    chk("abort_out_valid", sp_out_valid, 0);
    chk("abort_result", sp_result, 0);
    run_check(0, "after_abort", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27);

    run_random(0, 8, 23, 150);
    run_random(1, 5, 10, 150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

endmodule
